// File: rtl/axi_slv_pkg.sv
// axi_slv_pkg: shared AXI slave types and the burst legality rule.
package axi_slv_pkg;
    typedef enum logic [1:0] {FIXED, INCR, WRAP, RSVD} burst_e;
    typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} resp_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

    function automatic logic burst_legal(
        input logic [2:0] size,
        input logic [1:0] burst,
        input logic [3:0] len,
        input logic [6:0] addr_lo,
        input logic [2:0] lg_strb
    );
        logic [6:0] m;
        m = (7'd1 << size) - 7'd1;
        return size <= lg_strb && burst != RSVD &&
               (burst != WRAP || ((len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15) &&
                                  (addr_lo & m) == 7'd0));
    endfunction
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: next beat address and whole-burst window check.
module axi_burst_addr_gen
    import axi_slv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int WIN_BYTES = 8192
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  in_window
);
    typedef logic [ADDR_WIDTH:0] ax_t;
    localparam ax_t WIN_LO = ax_t'(BASE_ADDR);
    localparam ax_t WIN_HI = WIN_LO + ax_t'(WIN_BYTES);
    ax_t bytes, span, lo, hi;
    logic [ADDR_WIDTH-1:0] step, mask;
    always_comb begin
        bytes = ax_t'(1) << size;
        span = bytes * (ax_t'(len) + ax_t'(1));
        // the extra top bit catches bursts that run past the end of the address space
        lo = burst == WRAP ? {1'b0, addr} & ~(span - ax_t'(1)) : {1'b0, addr};
        hi = lo + (burst == FIXED ? bytes : span) - ax_t'(1);
        in_window = lo >= WIN_LO && hi < WIN_HI;
        step = ADDR_WIDTH'(bytes);
        mask = ADDR_WIDTH'(span - ax_t'(1));
        next_addr = burst == FIXED ? addr :
                    burst == WRAP ? (addr & ~mask) | ((addr + step) & mask) : addr + step;
    end
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave with internal word SRAM, one write and one read burst in flight.
module axi_sram_slave
    import axi_slv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH = 4,
    parameter int MEM_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [3:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic                    wlast,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [ID_WIDTH-1:0]     wid,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    output logic [ID_WIDTH-1:0]     bid,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [3:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic [ID_WIDTH-1:0]     arid,
    output logic                    rvalid,
    input  logic                    rready,
    output logic                    rlast,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic [ID_WIDTH-1:0]     rid,
    input  logic                    csysreq,
    output logic                    csysack,
    output logic                    cactive
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LG = $clog2(STRB_WIDTH);
    localparam int IW = $clog2(MEM_WORDS);
    localparam logic [2:0] LG3 = 3'(LG);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    wr_state_e ws;
    rd_state_e rs;
    logic [ADDR_WIDTH-1:0] waddr, raddr, wnext, rnext;
    logic [3:0] wlen, rlen, wbeat, rbeat;
    logic [2:0] wsize, rsize;
    logic [1:0] wburst, rburst;
    logic werr, wproto, rerr, win_ok, rin_ok;
    logic w_idle, r_idle, aw_hs, ar_hs, w_hs, aw_bad, ar_bad, w_final;

    function automatic logic [IW-1:0] widx(input logic [ADDR_WIDTH-1:0] a);
        return IW'((a - BASE_ADDR) >> LG);
    endfunction

    assign w_idle = ws == W_IDLE;
    assign r_idle = rs == R_IDLE;
    assign aw_hs = awvalid && awready;
    assign ar_hs = arvalid && arready;
    assign w_hs = wvalid && wready;
    assign w_final = wbeat == wlen;
    assign aw_bad = !burst_legal(awsize, awburst, awlen, awaddr[6:0], LG3) || !win_ok;
    assign ar_bad = !burst_legal(arsize, arburst, arlen, araddr[6:0], LG3) || !rin_ok;
    assign cactive = !w_idle || !r_idle || awvalid || arvalid;

    // while idle the generators judge the incoming request, otherwise they step the live burst
    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR), .WIN_BYTES(MEM_WORDS * STRB_WIDTH)) u_wgen (
        .addr(w_idle ? awaddr : waddr), .len(w_idle ? awlen : wlen), .size(w_idle ? awsize : wsize),
        .burst(w_idle ? awburst : wburst), .next_addr(wnext), .in_window(win_ok)
    );
    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR), .WIN_BYTES(MEM_WORDS * STRB_WIDTH)) u_rgen (
        .addr(r_idle ? araddr : raddr), .len(r_idle ? arlen : rlen), .size(r_idle ? arsize : rsize),
        .burst(r_idle ? arburst : rburst), .next_addr(rnext), .in_window(rin_ok)
    );

    always_ff @(posedge clk) begin
        if (ws == W_DATA && w_hs && !werr)
            for (int b = 0; b < STRB_WIDTH; b++)
                if (wstrb[b]) mem[widx(waddr)][8*b +: 8] <= wdata[8*b +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ws <= W_IDLE;
            awready <= 1'b0;
            wready <= 1'b0;
            bvalid <= 1'b0;
            bresp <= OKAY;
            bid <= '0;
            waddr <= '0;
            wlen <= '0;
            wsize <= '0;
            wburst <= '0;
            wbeat <= '0;
            werr <= 1'b0;
            wproto <= 1'b0;
        end else begin
            case (ws)
                W_IDLE: begin
                    if (aw_hs) begin
                        awready <= 1'b0;
                        wready <= 1'b1;
                        waddr <= awaddr;
                        wlen <= awlen;
                        wsize <= awsize;
                        wburst <= awburst;
                        bid <= awid;
                        wbeat <= '0;
                        werr <= aw_bad;
                        wproto <= 1'b0;
                        ws <= W_DATA;
                    end else awready <= csysreq;
                end
                W_DATA: begin
                    if (w_hs) begin
                        waddr <= wnext;
                        wbeat <= wbeat + 4'd1;
                        wproto <= wproto || (wlast != w_final);
                        if (w_final) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bresp <= (werr || wproto || !wlast) ? SLVERR : OKAY;
                            ws <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        awready <= csysreq;
                        ws <= W_IDLE;
                    end
                end
                default: ws <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs <= R_IDLE;
            arready <= 1'b0;
            rvalid <= 1'b0;
            rlast <= 1'b0;
            rdata <= '0;
            rresp <= OKAY;
            rid <= '0;
            raddr <= '0;
            rlen <= '0;
            rsize <= '0;
            rburst <= '0;
            rbeat <= '0;
            rerr <= 1'b0;
        end else begin
            case (rs)
                R_IDLE: begin
                    if (ar_hs) begin
                        arready <= 1'b0;
                        rvalid <= 1'b1;
                        rid <= arid;
                        rresp <= ar_bad ? SLVERR : OKAY;
                        rdata <= ar_bad ? '0 : mem[widx(araddr)];
                        rlast <= arlen == 4'd0;
                        raddr <= rnext;
                        rlen <= arlen;
                        rsize <= arsize;
                        rburst <= arburst;
                        rbeat <= '0;
                        rerr <= ar_bad;
                        rs <= R_DATA;
                    end else arready <= csysreq;
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid <= 1'b0;
                            rlast <= 1'b0;
                            arready <= csysreq;
                            rs <= R_IDLE;
                        end else begin
                            rdata <= rerr ? '0 : mem[widx(raddr)];
                            rlast <= rbeat + 4'd1 == rlen;
                            rbeat <= rbeat + 4'd1;
                            raddr <= rnext;
                        end
                    end
                end
                default: rs <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) csysack <= 1'b1;
        else if (csysreq) csysack <= 1'b1;
        else if (w_idle && r_idle && !aw_hs && !ar_hs) csysack <= 1'b0;
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed checks of bursts, strobes, errors, stalls and low-power handshake.
module tb_axi_sram_slave;
    logic clk = 1'b0, rst = 1'b1;
    logic awvalid = 0, awready, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
    logic arvalid = 0, arready, rvalid, rready = 0, rlast, csysreq = 1, csysack, cactive;
    logic [31:0] awaddr = 0, araddr = 0;
    logic [3:0] awlen = 0, arlen = 0, awid = 0, arid = 0, wid = 0, bid, rid;
    logic [2:0] awsize = 0, arsize = 0;
    logic [1:0] awburst = 0, arburst = 0, bresp, rresp;
    logic [63:0] wdata = 0, rdata;
    logic [7:0] wstrb = 0;
    logic [63:0] wbuf [16];
    logic [63:0] rexp [16];
    int total = 0, bad = 0;

    axi_sram_slave dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb), .wid(wid),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata), .rresp(rresp), .rid(rid),
        .csysreq(csysreq), .csysack(csysack), .cactive(cactive)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic aw(input logic [31:0] a, input logic [3:0] len, input logic [2:0] sz,
                      input logic [1:0] bu, input logic [3:0] id);
        int n = 0;
        awaddr = a; awlen = len; awsize = sz; awburst = bu; awid = id; awvalid = 1;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        chk("awready_wait", 64'(n < 50), 1);
        @(negedge clk);
        awvalid = 0;
    endtask

    task automatic ar(input logic [31:0] a, input logic [3:0] len, input logic [2:0] sz,
                      input logic [1:0] bu, input logic [3:0] id);
        int n = 0;
        araddr = a; arlen = len; arsize = sz; arburst = bu; arid = id; arvalid = 1;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        chk("arready_wait", 64'(n < 50), 1);
        @(negedge clk);
        arvalid = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] len, input logic [2:0] sz,
                      input logic [1:0] bu, input logic [7:0] st, input logic [3:0] id,
                      input logic [1:0] er, input string tag, input bit nolast, input bit lp);
        int n;
        aw(a, len, sz, bu, id);
        if (lp) begin
            csysreq = 0;
            chk({tag, "_cactive"}, 64'(cactive), 1);
        end
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbuf[i]; wstrb = st; wlast = !nolast && i == int'(len); wvalid = 1;
            n = 0;
            while (!wready && n < 50) begin @(negedge clk); n++; end
            chk({tag, "_wready"}, 64'(n < 50), 1);
            if (lp) chk({tag, "_ack_data"}, 64'(csysack), 1);
            @(negedge clk);
        end
        wvalid = 0; wlast = 0; bready = 1;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_bvalid"}, 64'(n < 50), 1);
        chk({tag, "_bresp"}, 64'(bresp), 64'(er));
        chk({tag, "_bid"}, 64'(bid), 64'(id));
        if (lp) chk({tag, "_ack_resp"}, 64'(csysack), 1);
        @(negedge clk);
        bready = 0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [3:0] len, input logic [2:0] sz,
                      input logic [1:0] bu, input logic [3:0] id, input logic [1:0] er, input string tag);
        int n;
        ar(a, len, sz, bu, id);
        rready = 1;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!rvalid && n < 50) begin @(negedge clk); n++; end
            chk({tag, "_rvalid"}, 64'(n < 50), 1);
            chk($sformatf("%s_data%0d", tag, i), rdata, rexp[i]);
            chk($sformatf("%s_last%0d", tag, i), 64'(rlast), 64'(i == int'(len)));
            chk($sformatf("%s_resp%0d", tag, i), 64'(rresp), 64'(er));
            chk($sformatf("%s_id%0d", tag, i), 64'(rid), 64'(id));
            @(negedge clk);
        end
        rready = 0;
        chk({tag, "_end"}, 64'(rvalid), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_awready", 64'(awready), 0);
        chk("rst_arready", 64'(arready), 0);
        chk("rst_wready", 64'(wready), 0);
        chk("rst_bvalid", 64'(bvalid), 0);
        chk("rst_rvalid", 64'(rvalid), 0);
        chk("rst_rlast", 64'(rlast), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_csysack", 64'(csysack), 1);
        chk("rst_cactive", 64'(cactive), 0);
        rst = 0;
        @(negedge clk);
        chk("post_rst_awready", 64'(awready), 1);
        chk("post_rst_arready", 64'(arready), 1);

        // INCR write then read back
        wbuf[0] = 1; wbuf[1] = 2; wbuf[2] = 3; wbuf[3] = 4;
        wr(32'h40, 3, 3, 1, 8'hFF, 4'h5, 2'b00, "incr_wr", 0, 0);
        rexp[0] = 1; rexp[1] = 2; rexp[2] = 3; rexp[3] = 4;
        rd(32'h40, 3, 3, 1, 4'h6, 2'b00, "incr_rd");

        // WRAP read from 0x38 visits 0x38,0x20,0x28,0x30
        wbuf[0] = 64'h21; wbuf[1] = 64'h22; wbuf[2] = 64'h23; wbuf[3] = 64'h24;
        wr(32'h20, 3, 3, 1, 8'hFF, 4'h1, 2'b00, "wrap_fill", 0, 0);
        rexp[0] = 64'h24; rexp[1] = 64'h21; rexp[2] = 64'h22; rexp[3] = 64'h23;
        rd(32'h38, 3, 3, 2, 4'h7, 2'b00, "wrap_rd");

        // byte strobes merge into the existing word
        wbuf[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        wr(32'h100, 0, 3, 1, 8'hFF, 4'h2, 2'b00, "strb_fill", 0, 0);
        wbuf[0] = 64'h5555_5555_5555_5555;
        wr(32'h100, 0, 3, 1, 8'h0F, 4'h2, 2'b00, "strb_wr", 0, 0);
        rexp[0] = 64'hAAAA_AAAA_5555_5555;
        rd(32'h100, 0, 3, 1, 4'h3, 2'b00, "strb_rd");

        // illegal accesses: SLVERR and no memory change
        wbuf[0] = 64'h1234; wr(32'h0, 0, 3, 1, 8'hFF, 4'h0, 2'b00, "pre0", 0, 0);
        wbuf[0] = 64'hBEEF; wr(32'h1FF8, 0, 3, 1, 8'hFF, 4'h0, 2'b00, "pre_top", 0, 0);
        wbuf[0] = 64'hDEAD; wbuf[1] = 64'hDEAD;
        wr(32'h100, 0, 4, 1, 8'hFF, 4'hA, 2'b10, "size_wr", 0, 0);
        wr(32'h2000, 0, 3, 1, 8'hFF, 4'hB, 2'b10, "oow_wr", 0, 0);
        wr(32'h1FF8, 1, 3, 1, 8'hFF, 4'hC, 2'b10, "cross_wr", 0, 0);
        wr(32'h0, 0, 3, 3, 8'hFF, 4'hD, 2'b10, "rsvd_wr", 0, 0);
        rexp[0] = 64'hAAAA_AAAA_5555_5555;
        rd(32'h100, 0, 3, 1, 4'h3, 2'b00, "size_chk");
        rexp[0] = 64'h1234;
        rd(32'h0, 0, 3, 1, 4'h3, 2'b00, "oow_chk");
        rexp[0] = 64'hBEEF;
        rd(32'h1FF8, 0, 3, 1, 4'h3, 2'b00, "cross_chk");
        rexp[0] = 0; rexp[1] = 0; rexp[2] = 0;
        rd(32'h100, 1, 4, 1, 4'h8, 2'b10, "size_rd");
        rd(32'h2000, 2, 3, 1, 4'h9, 2'b10, "oow_rd");
        rd(32'h20, 2, 3, 2, 4'h9, 2'b10, "wraplen_rd");
        rd(32'h3C, 1, 3, 2, 4'h9, 2'b10, "wrapalign_rd");

        // missing wlast on the final beat
        wbuf[0] = 64'h31; wbuf[1] = 64'h32;
        wr(32'h300, 1, 3, 1, 8'hFF, 4'hE, 2'b10, "nolast_wr", 1, 0);

        // rready stall mid-burst
        ar(32'h40, 3, 3, 1, 4'h2);
        rready = 1;
        chk("stall_d0", rdata, 1);
        @(negedge clk);
        rready = 0;
        repeat (3) begin
            chk("stall_hold_data", rdata, 2);
            chk("stall_hold_last", 64'(rlast), 0);
            chk("stall_hold_valid", 64'(rvalid), 1);
            @(negedge clk);
        end
        rready = 1;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("stall_d%0d", i), rdata, 64'(i + 1));
            chk($sformatf("stall_l%0d", i), 64'(rlast), 64'(i == 3));
            @(negedge clk);
        end
        rready = 0;
        chk("stall_end", 64'(rvalid), 0);

        // low-power request during a write burst
        wbuf[0] = 64'h81; wbuf[1] = 64'h82;
        wr(32'h80, 1, 3, 1, 8'hFF, 4'h9, 2'b00, "lp", 0, 1);
        chk("lp_ack_after_b", 64'(csysack), 1);
        chk("lp_awready_off", 64'(awready), 0);
        @(negedge clk);
        chk("lp_ack_drop", 64'(csysack), 0);
        chk("lp_arready_off", 64'(arready), 0);
        chk("lp_cactive", 64'(cactive), 0);
        repeat (2) @(negedge clk);
        chk("lp_awready_hold", 64'(awready), 0);
        csysreq = 1;
        @(negedge clk);
        chk("lp_ack_back", 64'(csysack), 1);
        chk("lp_awready_back", 64'(awready), 1);
        chk("lp_arready_back", 64'(arready), 1);
        rexp[0] = 64'h81; rexp[1] = 64'h82;
        rd(32'h80, 1, 3, 1, 4'h1, 2'b00, "lp_rd");

        // reset mid-burst keeps already-written bytes and issues no response
        aw(32'h200, 3, 3, 1, 4'h3);
        wdata = 64'h77; wstrb = 8'hFF; wlast = 0; wvalid = 1;
        chk("mid_wready", 64'(wready), 1);
        @(negedge clk);
        wvalid = 0;
        rst = 1;
        #1;
        chk("mid_bvalid", 64'(bvalid), 0);
        chk("mid_wready_rst", 64'(wready), 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("mid_awready", 64'(awready), 1);
        chk("mid_bvalid_after", 64'(bvalid), 0);
        rexp[0] = 64'h77;
        rd(32'h200, 0, 3, 1, 4'h4, 2'b00, "mid_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
